// File: rtl/m_store_pkg.sv
// m_store_pkg: shared encodings, address windows and entry layout
// for the M-stage store buffer.
package m_store_pkg;

    localparam logic [1:0] BE_NONE = 2'b00;
    localparam logic [1:0] BE_SW   = 2'b01;
    localparam logic [1:0] BE_SH   = 2'b10;
    localparam logic [1:0] BE_SB   = 2'b11;

    localparam logic [31:0] DM_END_DEF   = 32'h0000_2fff;
    localparam logic [31:0] TC1_BASE_DEF = 32'h0000_7f00;
    localparam logic [31:0] TC2_BASE_DEF = 32'h0000_7f10;
    localparam logic [31:0] TC_SIZE      = 32'd12;
    localparam logic [31:0] TC_CNT_OFF   = 32'd8;

    typedef struct packed {
        logic        valid;
        logic [29:0] waddr;
        logic [3:0]  byteen;
        logic [31:0] data;
    } sb_entry_t;

endpackage

// File: rtl/m_store_check.sv
// m_store_check: store address exception detection and
// byte-lane / write-data generation, purely combinational.
module m_store_check
    import m_store_pkg::*;
#(
    parameter logic [31:0] DM_END   = DM_END_DEF,
    parameter logic [31:0] TC1_BASE = TC1_BASE_DEF,
    parameter logic [31:0] TC2_BASE = TC2_BASE_DEF
) (
    input  logic        st_valid,
    input  logic [1:0]  st_op,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic        st_addr_ov,
    output logic        exc_ades,
    output logic [3:0]  byteen,
    output logic [31:0] wdata,
    output logic        is_timer
);

    logic in_dm;
    logic in_tc1;
    logic in_tc2;
    logic cnt_reg;
    logic align_err;
    logic range_err;
    logic timer_err;

    assign in_dm  = st_addr <= DM_END;
    assign in_tc1 = (st_addr >= TC1_BASE)
                 && (st_addr <= TC1_BASE + TC_SIZE - 32'd1);
    assign in_tc2 = (st_addr >= TC2_BASE)
                 && (st_addr <= TC2_BASE + TC_SIZE - 32'd1);

    // Count registers sit in the last word of each timer window.
    assign cnt_reg = (in_tc1 && st_addr >= TC1_BASE + TC_CNT_OFF)
                  || (in_tc2 && st_addr >= TC2_BASE + TC_CNT_OFF);

    assign is_timer  = in_tc1 || in_tc2;
    assign align_err = (st_op == BE_SW && st_addr[1:0] != 2'b00)
                    || (st_op == BE_SH && st_addr[0]);
    assign range_err = !(in_dm || is_timer);
    assign timer_err = cnt_reg || (is_timer && st_op != BE_SW);

    assign exc_ades = st_valid && st_op != BE_NONE
                   && (align_err || range_err
                       || timer_err || st_addr_ov);

    // Place the store data into its byte lanes; unused lanes are zero.
    always_comb begin
        byteen = 4'b0000;
        wdata  = 32'h0;
        unique case (st_op)
            BE_SW: begin
                byteen = 4'b1111;
                wdata  = st_data;
            end
            BE_SH: begin
                byteen = st_addr[1] ? 4'b1100 : 4'b0011;
                wdata  = st_addr[1] ? {st_data[15:0], 16'h0}
                                    : {16'h0, st_data[15:0]};
            end
            BE_SB: begin
                byteen = 4'b0001 << st_addr[1:0];
                wdata  = {24'h0, st_data[7:0]} << {st_addr[1:0], 3'b000};
            end
            BE_NONE: begin
                byteen = 4'b0000;
                wdata  = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/m_store_buffer.sv
// m_store_buffer: M-stage store FIFO with tail coalescing,
// req/ack drain to the DM/timer bridge and load hazard detection.
module m_store_buffer
    import m_store_pkg::*;
#(
    parameter int          DEPTH       = 4,
    parameter logic [31:0] DM_END      = DM_END_DEF,
    parameter logic [31:0] TC1_BASE    = TC1_BASE_DEF,
    parameter logic [31:0] TC2_BASE    = TC2_BASE_DEF,
    parameter bit          COALESCE_EN = 1'b1,
    localparam int         PW          = $clog2(DEPTH),
    localparam int         CW          = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          st_valid,
    input  logic [1:0]    st_op,
    input  logic [31:0]   st_addr,
    input  logic [31:0]   st_data,
    input  logic          st_addr_ov,
    input  logic          st_kill,
    output logic          st_ready,
    output logic          exc_ades,
    input  logic          ld_valid,
    input  logic [31:0]   ld_addr,
    output logic          ld_hazard,
    output logic          bus_req,
    output logic [31:0]   bus_addr,
    output logic [3:0]    bus_byteen,
    output logic [31:0]   bus_wdata,
    input  logic          bus_ack,
    output logic [CW-1:0] count,
    output logic          empty
);

    sb_entry_t     q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] tail_last;
    logic [3:0]    st_be;
    logic [31:0]   st_wd;
    logic [31:0]   st_mask;
    logic          st_timer;
    logic          hit;
    logic          push;
    logic          alloc;
    logic          merge;
    logic          pop;
    logic          ld_match;
    logic [1:0]    unused_ld_lsb;

    m_store_check #(
        .DM_END   (DM_END),
        .TC1_BASE (TC1_BASE),
        .TC2_BASE (TC2_BASE)
    ) u_check (
        .st_valid   (st_valid),
        .st_op      (st_op),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_addr_ov (st_addr_ov),
        .exc_ades   (exc_ades),
        .byteen     (st_be),
        .wdata      (st_wd),
        .is_timer   (st_timer)
    );

    // The tail entry is the most recently allocated slot.
    assign tail_last = tail - PW'(1);
    assign st_mask   = {{8{st_be[3]}}, {8{st_be[2]}},
                        {8{st_be[1]}}, {8{st_be[0]}}};

    // With a single entry the tail is already on the bus: never merge.
    assign hit = COALESCE_EN
              && count >= CW'(2)
              && q[tail_last].waddr == st_addr[31:2]
              && !st_timer;

    assign st_ready = hit || count < CW'(DEPTH);
    assign push     = st_valid && st_op != BE_NONE
                   && !exc_ades && !st_kill && st_ready;
    assign merge    = push && hit;
    assign alloc    = push && !hit;
    assign pop      = bus_req && bus_ack;

    assign empty      = count == '0;
    assign bus_req    = !empty;
    assign bus_addr   = {q[head].waddr, 2'b00};
    assign bus_byteen = q[head].byteen;
    assign bus_wdata  = q[head].data;

    // FIFO state: allocate at tail, merge into tail entry, pop at head.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
        end else begin
            if (alloc) begin
                q[tail] <= '{valid: 1'b1, waddr: st_addr[31:2],
                             byteen: st_be, data: st_wd};
                tail    <= tail + PW'(1);
            end
            if (merge) begin
                q[tail_last].byteen <= q[tail_last].byteen | st_be;
                q[tail_last].data   <= (q[tail_last].data & ~st_mask)
                                     | (st_wd & st_mask);
            end
            if (pop) begin
                q[head].valid <= 1'b0;
                head          <= head + PW'(1);
            end
            case ({alloc, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Any valid entry in the load's word means the load must wait.
    always_comb begin
        ld_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q[i].valid && q[i].waddr == ld_addr[31:2]) begin
                ld_match = 1'b1;
            end
        end
    end

    assign ld_hazard     = ld_valid && ld_match;
    assign unused_ld_lsb = ld_addr[1:0];

endmodule

// File: tb/tb_m_store_buffer.sv
// tb_m_store_buffer: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_m_store_buffer;
    import m_store_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [1:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_addr_ov;
    logic        st_kill;
    logic        st_ready;
    logic        exc_ades;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [3:0]  bus_byteen;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [2:0]  count;
    logic        empty;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [29:0] w;
        logic [3:0]  be;
        logic [31:0] d;
    } ment_t;

    ment_t mq[$];

    always #5 clk = ~clk;

    m_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .st_valid   (st_valid),
        .st_op      (st_op),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_addr_ov (st_addr_ov),
        .st_kill    (st_kill),
        .st_ready   (st_ready),
        .exc_ades   (exc_ades),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_hazard  (ld_hazard),
        .bus_req    (bus_req),
        .bus_addr   (bus_addr),
        .bus_byteen (bus_byteen),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .count      (count),
        .empty      (empty)
    );

    function automatic bit m_win(logic [31:0] a, logic [31:0] base);
        return a >= base && a < base + 32'd12;
    endfunction

    function automatic bit m_timer(logic [31:0] a);
        return m_win(a, 32'h7f00) || m_win(a, 32'h7f10);
    endfunction

    function automatic bit m_exc(logic [1:0] op, logic [31:0] a,
                                 logic ov);
        bit t1, t2, al, rg, tm;
        if (op == BE_NONE) return 1'b0;
        t1 = m_win(a, 32'h7f00);
        t2 = m_win(a, 32'h7f10);
        al = (op == BE_SW && a % 4 != 0) || (op == BE_SH && a % 2 != 0);
        rg = !(a <= 32'h2fff || t1 || t2);
        tm = (t1 && a - 32'h7f00 >= 8) || (t2 && a - 32'h7f10 >= 8)
          || ((t1 || t2) && op != BE_SW);
        return al || rg || tm || ov;
    endfunction

    task automatic m_lanes(input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] d,
                           output logic [3:0] be, output logic [31:0] wd);
        int off;
        off = a % 4;
        be  = 4'h0;
        wd  = 32'h0;
        if (op == BE_SW) begin
            be = 4'hf;
            wd = d;
        end else if (op == BE_SH) begin
            be = (off >= 2) ? 4'hc : 4'h3;
            wd = (off >= 2) ? (d & 32'hffff) * 32'h10000 : d & 32'hffff;
        end else if (op == BE_SB) begin
            be = 4'(1 << off);
            wd = (d & 32'hff) << (8 * off);
        end
    endtask

    function automatic bit m_hit(logic [31:0] a);
        if (mq.size() < 2) return 1'b0;
        return mq[mq.size()-1].w == a[31:2] && !m_timer(a);
    endfunction

    function automatic bit m_ready(logic [31:0] a);
        return m_hit(a) || mq.size() < DEPTH;
    endfunction

    function automatic bit m_hazard();
        if (!ld_valid) return 1'b0;
        foreach (mq[i]) if (mq[i].w == ld_addr[31:2]) return 1'b1;
        return 1'b0;
    endfunction

    // Advance the reference model by one clock using current inputs.
    task automatic m_step();
        bit push, hit, pop;
        logic [3:0]  be;
        logic [31:0] wd;
        ment_t e;
        if (reset) begin
            mq.delete();
            return;
        end
        hit  = m_hit(st_addr);
        push = st_valid && st_op != BE_NONE && !st_kill
            && !m_exc(st_op, st_addr, st_addr_ov) && m_ready(st_addr);
        pop  = mq.size() > 0 && bus_ack;
        m_lanes(st_op, st_addr, st_data, be, wd);
        if (push && hit) begin
            e = mq[mq.size()-1];
            for (int b = 0; b < 4; b++)
                if (be[b]) e.d[8*b +: 8] = wd[8*b +: 8];
            e.be = e.be | be;
            mq[mq.size()-1] = e;
        end
        if (pop) void'(mq.pop_front());
        if (push && !hit) mq.push_back('{w: st_addr[31:2], be: be, d: wd});
    endtask

    task automatic tick();
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_st(input logic v, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] d);
        st_valid   = v;
        st_op      = op;
        st_addr    = a;
        st_data    = d;
        st_addr_ov = 1'b0;
        st_kill    = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        ld_valid = 1'b1;
        ld_addr  = 32'h0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
        n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", bus_req); end
        n_checks++; if ({bus_addr, bus_byteen, bus_wdata} !== 68'h0) begin n_fail++; $display("FAIL reset_bus got %h/%h/%h want 0", bus_addr, bus_byteen, bus_wdata); end
        n_checks++; if (ld_hazard !== 1'b0) begin n_fail++; $display("FAIL reset_hazard got %b want 0", ld_hazard); end
        ld_valid = 1'b0;
    endtask

    task automatic test_single_sw();
        bus_ack = 1'b1;
        set_st(1'b1, BE_SW, 32'h10, 32'hdeadbeef);
        #1;
        n_checks++; if (st_ready !== 1'b1 || exc_ades !== 1'b0) begin n_fail++; $display("FAIL sw_accept got rdy=%b exc=%b want 1/0", st_ready, exc_ades); end
        tick();
        set_st(1'b0, BE_NONE, 32'h0, 32'h0);
        #1;
        n_checks++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL sw_req got %b want 1", bus_req); end
        n_checks++; if (bus_addr !== 32'h10 || bus_byteen !== 4'hf) begin n_fail++; $display("FAIL sw_bus got %h/%h want 10/f", bus_addr, bus_byteen); end
        n_checks++; if (bus_wdata !== 32'hdeadbeef) begin n_fail++; $display("FAIL sw_wdata got %h want deadbeef", bus_wdata); end
        tick();
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL sw_drain got %b want 1", empty); end
    endtask

    task automatic test_coalesce();
        bus_ack = 1'b0;
        set_st(1'b1, BE_SB, 32'h20, 32'h000000aa);
        tick();
        set_st(1'b1, BE_SB, 32'h24, 32'h00000011);
        tick();
        set_st(1'b1, BE_SB, 32'h25, 32'h00000022);
        tick();
        set_st(1'b0, BE_NONE, 32'h0, 32'h0);
        #1;
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL coal_count got %0d want 2", count); end
        n_checks++; if (bus_addr !== 32'h20 || bus_byteen !== 4'h1 || bus_wdata !== 32'haa) begin n_fail++; $display("FAIL coal_head got %h/%h/%h want 20/1/aa", bus_addr, bus_byteen, bus_wdata); end
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        #1;
        n_checks++; if (bus_addr !== 32'h24 || bus_byteen !== 4'h3) begin n_fail++; $display("FAIL coal_tail got %h/%h want 24/3", bus_addr, bus_byteen); end
        n_checks++; if (bus_wdata !== 32'h00002211) begin n_fail++; $display("FAIL coal_data got %h want 00002211", bus_wdata); end
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
    endtask

    task automatic test_exc();
        bus_ack = 1'b0;
        set_st(1'b1, BE_SH, 32'h7f02, 32'h1);
        #1;
        n_checks++; if (exc_ades !== 1'b1) begin n_fail++; $display("FAIL exc_sh_timer got %b want 1", exc_ades); end
        tick();
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL exc_nopush got %0d want 0", count); end
        set_st(1'b1, BE_SW, 32'h7f08, 32'h2);
        #1;
        n_checks++; if (exc_ades !== 1'b1) begin n_fail++; $display("FAIL exc_cnt_reg got %b want 1", exc_ades); end
        set_st(1'b1, BE_SW, 32'h7f04, 32'h3);
        #1;
        n_checks++; if (exc_ades !== 1'b0) begin n_fail++; $display("FAIL exc_tc1_ok got %b want 0", exc_ades); end
        tick();
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL exc_tc1_push got %0d want 1", count); end
        set_st(1'b1, BE_SW, 32'h3000, 32'h4);
        #1;
        n_checks++; if (exc_ades !== 1'b1) begin n_fail++; $display("FAIL exc_range got %b want 1", exc_ades); end
        set_st(1'b1, BE_SW, 32'h1, 32'h5);
        #1;
        n_checks++; if (exc_ades !== 1'b1) begin n_fail++; $display("FAIL exc_align got %b want 1", exc_ades); end
        set_st(1'b1, BE_SB, 32'h2fff, 32'h6);
        #1;
        n_checks++; if (exc_ades !== 1'b0) begin n_fail++; $display("FAIL exc_dm_end got %b want 0", exc_ades); end
        set_st(1'b1, BE_SW, 32'h7f14, 32'h7);
        st_addr_ov = 1'b1;
        #1;
        n_checks++; if (exc_ades !== 1'b1) begin n_fail++; $display("FAIL exc_ov got %b want 1", exc_ades); end
        set_st(1'b0, BE_NONE, 32'h0, 32'h0);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
    endtask

    task automatic test_full();
        bus_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_st(1'b1, BE_SW, 32'h100 + 32'(4 * i), 32'(i));
            tick();
        end
        set_st(1'b1, BE_SW, 32'h110, 32'h55);
        #1;
        n_checks++; if (st_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", st_ready); end
        tick();
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_nopush got %0d want 4", count); end
        set_st(1'b0, BE_NONE, 32'h0, 32'h0);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        #1;
        n_checks++; if (count !== 3'd3 || st_ready !== 1'b1) begin n_fail++; $display("FAIL full_pop got %0d/%b want 3/1", count, st_ready); end
        bus_ack = 1'b1;
        repeat (3) tick();
        bus_ack = 1'b0;
    endtask

    task automatic test_hazard();
        bus_ack = 1'b0;
        set_st(1'b1, BE_SW, 32'h40, 32'h9);
        tick();
        set_st(1'b0, BE_NONE, 32'h0, 32'h0);
        ld_valid = 1'b1;
        ld_addr  = 32'h42;
        #1;
        n_checks++; if (ld_hazard !== 1'b1) begin n_fail++; $display("FAIL haz_hit got %b want 1", ld_hazard); end
        ld_addr = 32'h44;
        #1;
        n_checks++; if (ld_hazard !== 1'b0) begin n_fail++; $display("FAIL haz_other got %b want 0", ld_hazard); end
        ld_addr = 32'h42;
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        n_checks++; if (ld_hazard !== 1'b0) begin n_fail++; $display("FAIL haz_clear got %b want 0", ld_hazard); end
        ld_valid = 1'b0;
    endtask

    task automatic test_kill_reset();
        bus_ack = 1'b0;
        set_st(1'b1, BE_SW, 32'h80, 32'h1);
        st_kill = 1'b1;
        tick();
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL kill_nopush got %0d want 0", count); end
        for (int i = 0; i < 3; i++) begin
            set_st(1'b1, BE_SW, 32'h200 + 32'(4 * i), 32'(i));
            tick();
        end
        set_st(1'b0, BE_NONE, 32'h0, 32'h0);
        n_checks++; if (count !== 3'd3 || bus_req !== 1'b1) begin n_fail++; $display("FAIL kill_fill got %0d/%b want 3/1", count, bus_req); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (count !== 3'd0 || bus_req !== 1'b0) begin n_fail++; $display("FAIL rst_drain got %0d/%b want 0/0", count, bus_req); end
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 600; c++) begin
            reset      = ($urandom_range(0, 99) == 0);
            st_valid   = ($urandom_range(0, 3) != 0);
            st_op      = 2'($urandom_range(0, 3));
            r          = $urandom_range(0, 9);
            if (r < 7)       st_addr = 32'($urandom_range(0, 47));
            else if (r == 7) st_addr = 32'h7f00 + 32'($urandom_range(0, 27));
            else if (r == 8) st_addr = 32'h2ff0 + 32'($urandom_range(0, 31));
            else             st_addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (st_op == BE_SW) st_addr[1:0] = 2'b00;
                if (st_op == BE_SH) st_addr[0] = 1'b0;
            end
            st_data    = $urandom;
            st_addr_ov = ($urandom_range(0, 19) == 0);
            st_kill    = ($urandom_range(0, 9) == 0);
            ld_valid   = $urandom_range(0, 1);
            ld_addr    = 32'($urandom_range(0, 47));
            bus_ack    = ($urandom_range(0, 2) == 0);
            #1;
            n_checks++; if (exc_ades !== (st_valid && m_exc(st_op, st_addr, st_addr_ov))) begin n_fail++; $display("FAIL rnd_exc c=%0d got %b op=%0d a=%h", c, exc_ades, st_op, st_addr); end
            n_checks++; if (st_ready !== m_ready(st_addr)) begin n_fail++; $display("FAIL rnd_ready c=%0d got %b want %b", c, st_ready, m_ready(st_addr)); end
            n_checks++; if (ld_hazard !== m_hazard()) begin n_fail++; $display("FAIL rnd_hazard c=%0d got %b want %b", c, ld_hazard, m_hazard()); end
            n_checks++; if (count !== 3'(mq.size()) || empty !== (mq.size() == 0) || bus_req !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_count c=%0d got %0d want %0d", c, count, mq.size()); end
            if (mq.size() != 0) begin
                n_checks++; if (bus_addr !== {mq[0].w, 2'b00} || bus_byteen !== mq[0].be || bus_wdata !== mq[0].d) begin n_fail++; $display("FAIL rnd_head c=%0d got %h/%h/%h want %h/%h/%h", c, bus_addr, bus_byteen, bus_wdata, {mq[0].w, 2'b00}, mq[0].be, mq[0].d); end
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        bus_ack  = 1'b0;
        ld_valid = 1'b0;
        ld_addr  = 32'h0;
        set_st(1'b0, BE_NONE, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        test_reset();
        test_single_sw();
        test_coalesce();
        test_exc();
        test_full();
        test_hazard();
        test_kill_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
